// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg
// Shared definitions for the Hyperbus native memory interface.
//   - state_t : one-hot FSM encoding of the responder (IDLE/LAT/READ/WRITE).
//   - cmd_t   : transaction direction, encoded the same way as in the
//               FIFO bridge on the initiator side.
package hyperbus_pkg;

  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_LAT_BIT   = 1;
  localparam int ST_READ_BIT  = 2;
  localparam int ST_WRITE_BIT = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'(1 << ST_IDLE_BIT),
    ST_LAT   = 4'(1 << ST_LAT_BIT),
    ST_READ  = 4'(1 << ST_READ_BIT),
    ST_WRITE = 4'(1 << ST_WRITE_BIT)
  } state_t;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_t;

endpackage

// File: rtl/hyperbus_native_ram_if.sv
// hyperbus_native_ram_if
// Bus bundle between a Hyperbus initiator and the native RAM responder.
//   master : drives hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq
//   slave  : drives hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
//
// Handshake: a transaction starts on the clock edge where rrq|wrq is seen
// rising while the responder is idle. After a fixed initial latency the
// responder holds hbus_ready (write) or hbus_valid (read) high for exactly
// the burst length, one word per cycle, with no backpressure. On a write
// the responder samples hbus_dat_i on every edge where hbus_ready is high;
// on a read hbus_dat_o is meaningful only while hbus_valid is high.
// hbus_busy covers the whole transaction from acceptance to completion.
interface hyperbus_native_ram_if #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16
) ();

  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
  logic                       hbus_rrq;
  logic                       hbus_wrq;
  logic                       hbus_ready;
  logic                       hbus_valid;
  logic                       hbus_busy;

  modport master (
    output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

  modport slave (
    input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

endinterface

// File: rtl/hyperbus_ram_array.sv
// hyperbus_ram_array
// Single-port synchronous RAM, 2**MEM_ADDR_WIDTH words of HBUS_DATA_WIDTH.
// Registered read (read-before-write), write enable; maps onto block RAM.
//   clk   : clock
//   we    : write wdata to mem[addr] on this edge
//   addr  : word address
//   wdata : write data
//   rdata : mem[addr] as seen at the previous edge
module hyperbus_ram_array #(
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int HBUS_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [MEM_ADDR_WIDTH-1:0]  addr,
  input  logic [HBUS_DATA_WIDTH-1:0] wdata,
  output logic [HBUS_DATA_WIDTH-1:0] rdata
);

  logic [HBUS_DATA_WIDTH-1:0] mem [0:(1 << MEM_ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hyperbus_native_ram.sv
// hyperbus_native_ram
// Responder end of the Hyperbus native memory interface. Accepts a rising
// read/write request, waits LATENCY cycles, then streams BURST_WORDS words
// to/from on-chip RAM. Stand-in for an external HyperRAM controller.
//   hbus_clk  : clock
//   hbus_rst  : asynchronous active-high reset (RAM contents kept)
//   bus       : hyperbus_native_ram_if slave modport (address, data,
//               rrq/wrq in; dat_o, ready, valid, busy out)
//   dbg_state : current one-hot FSM state
// Optional: define HYPERBUS_NATIVE_RAM_REFRESH_EN to model periodic refresh;
// a request accepted while a refresh is pending sees twice the latency.
module hyperbus_native_ram
  import hyperbus_pkg::*;
#(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int LATENCY         = 6,
  parameter int BURST_WORDS     = 2,
  parameter int REFRESH_PERIOD  = 400
) (
  input  logic                   hbus_clk,
  input  logic                   hbus_rst,
  hyperbus_native_ram_if.slave   bus,
  output state_t                 dbg_state
);

  localparam int CW = 9;  // holds 2*LATENCY up to 510
  localparam logic [CW-1:0] LAT_1 = CW'(LATENCY);
  localparam logic [7:0]    LAST  = 8'(BURST_WORDS - 1);

  state_t                     state;
  cmd_t                       dir;
  logic                       prev_req;
  logic [MEM_ADDR_WIDTH-1:0]  base;
  logic [7:0]                 k;
  logic [CW-1:0]              lat_cnt;
  logic [CW-1:0]              lat_load;
  logic                       ready_r;
  logic                       valid_r;
  logic                       busy_r;
  logic                       req;
  logic                       accept;
  logic [MEM_ADDR_WIDTH-1:0]  off;
  logic [MEM_ADDR_WIDTH-1:0]  ram_addr;
  logic                       ram_we;
  logic [HBUS_DATA_WIDTH-1:0] ram_rdata;

  assign req    = bus.hbus_rrq | bus.hbus_wrq;
  assign accept = (state == ST_IDLE) && req && !prev_req;

`ifdef HYPERBUS_NATIVE_RAM_REFRESH_EN
  localparam int RW = $clog2(REFRESH_PERIOD) + 1;
  localparam logic [CW-1:0] LAT_2 = CW'(2 * LATENCY);
  logic [RW-1:0] ref_cnt;
  logic          ref_tick;
  logic          refresh_pending;

  assign ref_tick = (ref_cnt == RW'(REFRESH_PERIOD - 1));
  assign lat_load = refresh_pending ? LAT_2 : LAT_1;

  // A tick on the acceptance edge wins, so it carries to the next request.
  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      if (ref_tick)    refresh_pending <= 1'b1;
      else if (accept) refresh_pending <= 1'b0;
    end
  end
`else
  localparam int UNUSED_REFRESH_PERIOD = REFRESH_PERIOD;
  assign lat_load = LAT_1;
`endif

  // Reads look one word ahead because the RAM output is registered:
  // during LAT the address is word 0, during READ it is word k+1.
  always_comb begin
    off = '0;
    if (state == ST_READ)  off = MEM_ADDR_WIDTH'(k) + MEM_ADDR_WIDTH'(1);
    if (state == ST_WRITE) off = MEM_ADDR_WIDTH'(k);
  end

  assign ram_addr = base + off;  // wraps modulo RAM depth
  assign ram_we   = (state == ST_WRITE);

  hyperbus_ram_array #(
    .MEM_ADDR_WIDTH  (MEM_ADDR_WIDTH),
    .HBUS_DATA_WIDTH (HBUS_DATA_WIDTH)
  ) u_ram (
    .clk   (hbus_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.hbus_dat_i),
    .rdata (ram_rdata)
  );

  // lat_cnt is loaded with the latency at acceptance and the data phase
  // begins on the edge where it reads 1, i.e. exactly L edges later.
  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state    <= ST_IDLE;
      dir      <= CMD_READ;
      prev_req <= 1'b0;
      base     <= '0;
      k        <= '0;
      lat_cnt  <= '0;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      prev_req <= req;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            base    <= bus.hbus_adr_i[MEM_ADDR_WIDTH-1:0];
            dir     <= bus.hbus_rrq ? CMD_READ : CMD_WRITE;
            lat_cnt <= lat_load;
            busy_r  <= 1'b1;
            state   <= ST_LAT;
          end
        end
        ST_LAT: begin
          if (lat_cnt == CW'(1)) begin
            k       <= '0;
            state   <= (dir == CMD_READ) ? ST_READ : ST_WRITE;
            valid_r <= (dir == CMD_READ);
            ready_r <= (dir == CMD_WRITE);
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_READ, ST_WRITE: begin
          if (k == LAST) begin
            state   <= ST_IDLE;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_r <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hbus_ready = ready_r;
  assign bus.hbus_valid = valid_r;
  assign bus.hbus_busy  = busy_r;
  assign bus.hbus_dat_o = valid_r ? ram_rdata : '0;
  assign dbg_state      = state;

  logic unused_adr_hi;
  assign unused_adr_hi = ^bus.hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

endmodule

// File: tb/tb_hyperbus_native_ram.sv
// tb_hyperbus_native_ram
// Directed bench for hyperbus_native_ram with L=6, B=2, 10-bit RAM.
module tb_hyperbus_native_ram;
  import hyperbus_pkg::*;

  localparam int L = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyperbus_native_ram_if #(.HBUS_ADDR_WIDTH(32), .HBUS_DATA_WIDTH(16)) bus ();
  state_t dbg_state;

  hyperbus_native_ram #(
    .HBUS_ADDR_WIDTH (32),
    .HBUS_DATA_WIDTH (16),
    .MEM_ADDR_WIDTH  (10),
    .LATENCY         (L),
    .BURST_WORDS     (2),
    .REFRESH_PERIOD  (400)
  ) dut (
    .hbus_clk  (clk),
    .hbus_rst  (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] adr,
                          input logic [15:0] w0, input logic [15:0] w1);
    bus.hbus_adr_i = adr;
    bus.hbus_dat_i = 16'(  $urandom_range(0, 16'hFFFF));
    bus.hbus_wrq   = 1'b1;
    tick();                                   // E0
    bus.hbus_wrq = 1'b0;
    check({tag, ".busy_e0"}, 32'(bus.hbus_busy), 32'd1);
    repeat (L - 1) tick();                    // E0+L-1
    check({tag, ".ready_early"}, 32'(bus.hbus_ready), 32'd0);
    tick();                                   // E0+L
    check({tag, ".ready_w0"}, 32'(bus.hbus_ready), 32'd1);
    bus.hbus_dat_i = w0;
    tick();                                   // E0+L+1: w0 written
    check({tag, ".ready_w1"}, 32'(bus.hbus_ready), 32'd1);
    bus.hbus_dat_i = w1;
    tick();                                   // E0+L+2: w1 written, done
    check({tag, ".ready_end"}, 32'(bus.hbus_ready), 32'd0);
    check({tag, ".busy_end"}, 32'(bus.hbus_busy), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] adr,
                         input logic [15:0] e0, input logic [15:0] e1,
                         input logic with_wrq);
    bus.hbus_adr_i = adr;
    bus.hbus_dat_i = 16'hDEAD;
    bus.hbus_rrq   = 1'b1;
    bus.hbus_wrq   = with_wrq;
    tick();                                   // E0
    bus.hbus_rrq = 1'b0;
    bus.hbus_wrq = 1'b0;
    check({tag, ".busy_e0"}, 32'(bus.hbus_busy), 32'd1);
    repeat (L - 1) tick();
    check({tag, ".valid_early"}, 32'(bus.hbus_valid), 32'd0);
    tick();                                   // E0+L
    check({tag, ".valid_w0"}, 32'(bus.hbus_valid), 32'd1);
    check({tag, ".dat_w0"}, 32'(bus.hbus_dat_o), 32'(e0));
    tick();                                   // E0+L+1
    check({tag, ".valid_w1"}, 32'(bus.hbus_valid), 32'd1);
    check({tag, ".dat_w1"}, 32'(bus.hbus_dat_o), 32'(e1));
    tick();                                   // E0+L+2
    check({tag, ".valid_end"}, 32'(bus.hbus_valid), 32'd0);
    check({tag, ".busy_end"}, 32'(bus.hbus_busy), 32'd0);
    check({tag, ".dat_end"}, 32'(bus.hbus_dat_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    rst            = 1'b1;
    bus.hbus_adr_i = '0;
    bus.hbus_dat_i = '0;
    bus.hbus_rrq   = 1'b0;
    bus.hbus_wrq   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst.ready", 32'(bus.hbus_ready), 32'd0);
    check("rst.valid", 32'(bus.hbus_valid), 32'd0);
    check("rst.busy",  32'(bus.hbus_busy),  32'd0);
    check("rst.dat",   32'(bus.hbus_dat_o), 32'd0);
    check("rst.state", 32'(dbg_state),      32'(ST_IDLE));

    // Basic write then read-back
    do_write("wr10", 32'h10, 16'hAAAA, 16'hBBBB);
    tick();
    do_read("rd10", 32'h10, 16'hAAAA, 16'hBBBB, 1'b0);
    tick();

    // Wrap from the top word to word 0
    do_write("wr001", 32'h001, 16'h3333, 16'h4444);
    tick();
    do_write("wr3ff", 32'h3FF, 16'h1111, 16'h2222);
    tick();
    do_read("rd3ff", 32'h3FF, 16'h1111, 16'h2222, 1'b0);
    tick();
    do_read("rd000", 32'h000, 16'h2222, 16'h3333, 1'b0);
    tick();

    // rrq and wrq together: read wins, RAM untouched by hbus_dat_i
    do_read("both", 32'h10, 16'hAAAA, 16'hBBBB, 1'b1);
    tick();
    do_read("both_after", 32'h10, 16'hAAAA, 16'hBBBB, 1'b0);
    tick();

    // Rising rrq during busy is ignored; a level held past completion
    // does not start another burst.
    bus.hbus_adr_i = 32'h10;
    bus.hbus_rrq   = 1'b1;
    tick();                                   // E0
    bus.hbus_rrq = 1'b0;
    tick();
    tick();
    bus.hbus_rrq = 1'b1;                      // rises while busy, then held
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.hbus_valid) nv++;
    end
    check("hold.valid_count", 32'(nv), 32'd2);
    check("hold.busy", 32'(bus.hbus_busy), 32'd0);
    check("hold.state", 32'(dbg_state), 32'(ST_IDLE));
    bus.hbus_rrq = 1'b0;
    tick();

    // Reset during the second write word
    do_write("wr20", 32'h20, 16'h5555, 16'h6666);
    tick();
    bus.hbus_adr_i = 32'h20;
    bus.hbus_wrq   = 1'b1;
    tick();                                   // E0
    bus.hbus_wrq = 1'b0;
    repeat (L) tick();                        // E0+L
    bus.hbus_dat_i = 16'h7777;
    tick();                                   // E0+L+1: word 0 written
    bus.hbus_dat_i = 16'h8888;
    #1 rst = 1'b1;
    #1;
    check("midrst.ready", 32'(bus.hbus_ready), 32'd0);
    check("midrst.busy",  32'(bus.hbus_busy),  32'd0);
    check("midrst.valid", 32'(bus.hbus_valid), 32'd0);
    check("midrst.state", 32'(dbg_state),      32'(ST_IDLE));
    tick();
    tick();
    rst = 1'b0;
    tick();
    do_read("rd20", 32'h20, 16'h7777, 16'h6666, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
